deadtime_gen: RTL and testbench
===============================

# deadtime_gen

Complementary gate-drive stage directly downstream of the SPWM comparator. Takes the single-ended PWM bit `p1` and produces non-overlapping high-side/low-side gate signals with programmable dead time on every transition. It suppresses pulses shorter than the dead time and forces both gates off on fault or disable. Runs in the 16 MHz `clk` domain, same as the SPWM block, so no synchroniser is needed on `pwm_in`.

## Interface
- `DT_W`, 8: width of dead-time count.
- `DT_MIN`, 1: floor applied to `dt_cycles`, in cycles.
- `clk`  in  1  system clock, 16 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  PWM command (`p1` of SPWM stage); 1 = high side on.
- `enable`  in  1  0 forces both gates off.
- `dt_cycles`  in  DT_W  dead time in clk cycles; sampled when a dead-time interval starts.
- `fault_in`  in  1  external trip, level.
- `fault_clr`  in  1  clears latched fault, pulse.
- `gate_hi`  out  1  high-side gate.
- `gate_lo`  out  1  low-side gate.
- `dt_active`  out  1  high while in a dead-time state.
- `fault_latched`  out  1  sticky fault status.

## Operation
- States: OFF, DT_TO_HI, HI, DT_TO_LO, LO, FAULT.
- Outputs are decoded from the state register only:
  - `gate_hi` = (state==HI).
  - `gate_lo` = (state==LO).
  - `dt_active` = DT_TO_HI or DT_TO_LO.
  - `fault_latched` = (state==FAULT).
- Effective dead time: `dt_eff = max(dt_cycles, DT_MIN)`. On entry to a DT state, the counter loads `dt_eff-1`.
- Priority per edge, highest first: `rst`, then `fault_in`, then `!enable`, then normal transitions.
- Any state with `fault_in`=1 goes to FAULT.
- FAULT goes to OFF only when `fault_clr`=1 and `fault_in`=0.
- Any non-FAULT state with `enable`=0 goes to OFF.
- Leaving OFF (with `enable`=1): `pwm_in`=1 goes to DT_TO_HI; `pwm_in`=0 goes to DT_TO_LO. Startup always incurs a full dead time.
- LO with `pwm_in`=1 goes to DT_TO_HI.
- HI with `pwm_in`=0 goes to DT_TO_LO.
- DT_TO_HI:
  - `pwm_in`=0: go to LO (pulse swallowed; `gate_hi` never asserted).
  - Otherwise, counter==0: go to HI.
  - Otherwise, decrement.
- DT_TO_LO: mirror of DT_TO_HI, returning to HI if `pwm_in`=1 reverts.
- Invariant: `gate_hi` & `gate_lo` is never 1.
- Invariant: every switch between the two gates passes through at least `dt_eff` cycles with both low, except for pulse-swallow returns to the previously active gate.

## Timing
- Reset value: state OFF, counter 0. All outputs 0.
- `pwm_in` change sampled at edge k:
  - The active gate drops after edge k (1-cycle latency).
  - The opposite gate rises after edge k+`dt_eff`.
- With `dt_cycles`=16: a 16-cycle gap with both gates low.
- `dt_cycles` changes mid-interval do not affect the running count.
- `fault_in` at edge k: both gates low after edge k; no dead-time wait.
- `rst` mid-dead-time: OFF next edge. Counter is cleared.
- `fault_in` and `fault_clr` both high on the same edge: stay in FAULT.
- After `fault_clr` releases the block, the first gate assertion still waits `dt_eff` cycles (OFF, then DT state).
- Pulse-swallow return (e.g. DT_TO_HI to LO) takes effect on the same edge that samples the reversion.

## Structure
- Shared package `spwm_pkg`:
  - state enum `dt_state_t`.
  - `DT_DEFAULT = 8'd16` (1 µs at 16 MHz).
  - `DT_W` default.
- One sub-module: `dt_counter` (loadable down-counter with `load`, `value`, `zero` flag). The FSM lives in `deadtime_gen`.

## Test plan
- **Startup:** reset, `enable`=1, `pwm_in`=1, `dt_cycles`=16 → `gate_hi` rises 16 cycles after OFF exit; `gate_lo` stays 0; `dt_active` high for exactly 16 cycles.
- **Steady toggling:** `pwm_in` square wave, period 100 cycles, `dt_cycles`=5 → each edge shows the active gate falling +1 cycle and the opposite gate rising +5 later; overlap never seen (assertion checked every cycle).
- **Pulse swallow:** in LO, `pwm_in` high for 3 cycles with `dt_cycles`=8 → `gate_hi` stays 0; `gate_lo` returns 1 on the cycle after `pwm_in` falls.
- **Zero dead time:** `dt_cycles`=0, `DT_MIN`=1 → one-cycle both-low gap on each transition.
- **Fault:** `fault_in` pulsed during HI → both gates 0 next edge, `fault_latched`=1. `fault_clr` with `fault_in` still high → stays latched. `fault_clr` after `fault_in` drops → OFF, then full dead time before any gate.
- **Reset and disable mid-operation:** `rst` asserted mid DT_TO_LO → all outputs 0 next edge, counter 0. `enable` dropped in HI → OFF next edge.

Source files
------------

// File: rtl/spwm_pkg.sv
// Shared types and constants for the SPWM gate-drive path.
package spwm_pkg;

    localparam int unsigned DT_W_DEFAULT = 8;
    // 1 us of dead time at 16 MHz
    localparam logic [7:0]  DT_DEFAULT   = 8'd16;

    typedef enum logic [2:0] {
        StOff,
        StDtToHi,
        StHi,
        StDtToLo,
        StLo,
        StFault
    } dt_state_t;

endpackage

// File: rtl/dt_counter.sv
// Loadable down-counter for dead-time intervals; holds at zero.
module dt_counter
    import spwm_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    input  logic [DT_W-1:0] value,
    output logic            zero
);

    logic [DT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (dec && !zero) begin
            count_d = count_q - DT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/deadtime_gen.sv
// Complementary gate driver with programmable dead time, pulse swallowing and fault latch.
module deadtime_gen
    import spwm_pkg::*;
#(
    parameter int unsigned DT_W   = DT_W_DEFAULT,
    parameter int unsigned DT_MIN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwm_in,
    input  logic            enable,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            dt_active,
    output logic            fault_latched
);

    localparam logic [DT_W-1:0] DtMinV = DT_W'(DT_MIN);

    dt_state_t       state_q, state_d;
    logic [DT_W-1:0] dt_eff;
    logic [DT_W-1:0] cnt_value;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic            dt_next;
    logic            dt_cur;

    assign dt_eff    = (dt_cycles < DtMinV) ? DtMinV : dt_cycles;
    assign cnt_value = dt_eff - DT_W'(1);

    always_comb begin
        state_d = state_q;
        if (fault_in) begin
            state_d = StFault;
        end else if (state_q == StFault) begin
            if (fault_clr) begin
                state_d = StOff;
            end
        end else if (!enable) begin
            state_d = StOff;
        end else begin
            case (state_q)
                StOff:    state_d = pwm_in ? StDtToHi : StDtToLo;
                StLo:     if (pwm_in) state_d = StDtToHi;
                StHi:     if (!pwm_in) state_d = StDtToLo;
                StDtToHi: begin
                    // A reverted command returns straight to the gate that was on
                    if (!pwm_in) begin
                        state_d = StLo;
                    end else if (cnt_zero) begin
                        state_d = StHi;
                    end
                end
                StDtToLo: begin
                    if (pwm_in) begin
                        state_d = StHi;
                    end else if (cnt_zero) begin
                        state_d = StLo;
                    end
                end
                default:  state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
        end else begin
            state_q <= state_d;
        end
    end

    // dt_cycles is captured only on entry, so mid-interval changes are ignored
    assign dt_next  = (state_d == StDtToHi) || (state_d == StDtToLo);
    assign dt_cur   = (state_q == StDtToHi) || (state_q == StDtToLo);
    assign cnt_load = dt_next && (state_d != state_q);
    assign cnt_dec  = dt_cur && (state_d == state_q);

    dt_counter #(
        .DT_W(DT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .value(cnt_value),
        .zero (cnt_zero)
    );

    always_comb begin
        gate_hi       = (state_q == StHi);
        gate_lo       = (state_q == StLo);
        dt_active     = dt_cur;
        fault_latched = (state_q == StFault);
    end

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: gap-timing reference model plus directed literal checks.
module tb_deadtime_gen;

    localparam int DT_W   = 8;
    localparam int DT_MIN = 1;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            pwm_in    = 1'b0;
    logic            enable    = 1'b0;
    logic [DT_W-1:0] dt_cycles = 8'd16;
    logic            fault_in  = 1'b0;
    logic            fault_clr = 1'b0;
    logic            gate_hi, gate_lo, dt_active, fault_latched;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deadtime_gen #(
        .DT_W  (DT_W),
        .DT_MIN(DT_MIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .enable       (enable),
        .dt_cycles    (dt_cycles),
        .fault_in     (fault_in),
        .fault_clr    (fault_clr),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo),
        .dt_active    (dt_active),
        .fault_latched(fault_latched)
    );

    // gate: 0 none, 1 high side, 2 low side; tgt: gate awaited during a gap (0 = no gap)
    typedef struct {
        bit fault;
        int gate;
        int tgt;
        int el;
        int eff;
    } model_t;

    model_t m       = '{0, 0, 0, 0, 0};
    bit     m_valid = 1'b0;

    function automatic model_t model_next(model_t s, bit r, bit fi, bit fc, bit en, bit p,
                                          int dt);
        model_t n    = s;
        int     want = p ? 1 : 2;
        if (r) begin
            n = '{0, 0, 0, 0, 0};
        end else if (fi) begin
            n.fault = 1'b1;
            n.gate  = 0;
            n.tgt   = 0;
        end else if (s.fault) begin
            if (fc) n.fault = 1'b0;
        end else if (!en) begin
            n.gate = 0;
            n.tgt  = 0;
        end else if (s.tgt != 0) begin
            if (want != s.tgt) begin
                n.gate = want;
                n.tgt  = 0;
            end else if (s.el >= s.eff) begin
                n.gate = s.tgt;
                n.tgt  = 0;
            end else begin
                n.el = s.el + 1;
            end
        end else if (s.gate != want) begin
            n.gate = 0;
            n.tgt  = want;
            n.el   = 1;
            n.eff  = (dt > DT_MIN) ? dt : DT_MIN;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, fault_in, fault_clr, enable, pwm_in, int'(dt_cycles));
        if (rst) m_valid <= 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gate_hi", int'(gate_hi), int'(m.gate == 1));
            check("model_gate_lo", int'(gate_lo), int'(m.gate == 2));
            check("model_dt_active", int'(dt_active), int'(m.tgt != 0));
            check("model_fault_latched", int'(fault_latched), int'(m.fault));
            check("no_overlap", int'(gate_hi & gate_lo), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts dead-time cycles until gate_hi rises (bounded)
    task automatic wait_hi(input string name, input int exp_gap);
        int n      = 0;
        int hi_at  = -1;
        bit seen_lo = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (gate_lo) seen_lo = 1'b1;
            if (gate_hi) begin
                hi_at = i;
                break;
            end
            if (dt_active) n++;
        end
        check({name, "_hi_rise"}, hi_at, exp_gap);
        check({name, "_dt_cycles"}, n, exp_gap);
        check({name, "_lo_quiet"}, int'(seen_lo), 0);
    endtask

    initial begin
        step();
        step();
        check("rst_outputs", int'({gate_hi, gate_lo, dt_active, fault_latched}), 0);
        check("rst_counter", int'(dut.u_counter.count_q), 0);

        // Startup with full 16-cycle dead time
        rst       = 1'b0;
        enable    = 1'b1;
        pwm_in    = 1'b1;
        dt_cycles = 8'd16;
        wait_hi("startup", 16);

        // Falling edge with dt=5: high drops next edge, low rises 5 edges after sampling
        dt_cycles = 8'd5;
        pwm_in    = 1'b0;
        step();
        check("fall_hi_drop", int'(gate_hi), 0);
        check("fall_dt_on", int'(dt_active), 1);
        repeat (4) step();
        check("fall_lo_wait", int'(gate_lo), 0);
        step();
        check("fall_lo_rise", int'(gate_lo), 1);

        // Square wave, period 100 cycles; ends settled in LO
        for (int c = 0; c < 6; c++) begin
            pwm_in = ~pwm_in;
            repeat (50) step();
        end
        check("square_end_lo", int'(gate_lo), 1);

        // Pulse swallow: 3-cycle high pulse inside an 8-cycle dead time
        dt_cycles = 8'd8;
        pwm_in    = 1'b1;
        step();
        check("swallow_dt", int'(dt_active), 1);
        check("swallow_lo_off", int'(gate_lo), 0);
        step();
        step();
        pwm_in = 1'b0;
        step();
        check("swallow_lo_back", int'(gate_lo), 1);
        check("swallow_hi_never", int'(gate_hi), 0);
        check("swallow_dt_off", int'(dt_active), 0);

        // dt_cycles change mid-interval must not alter the running count
        dt_cycles = 8'd5;
        pwm_in    = 1'b1;
        step();
        dt_cycles = 8'd20;
        repeat (4) step();
        check("dtchg_hi_wait", int'(gate_hi), 0);
        step();
        check("dtchg_hi_rise", int'(gate_hi), 1);

        // Zero dead time clamps to one cycle
        dt_cycles = 8'd0;
        pwm_in    = 1'b0;
        step();
        check("zero_gap_both", int'({gate_hi, gate_lo}), 0);
        check("zero_gap_dt", int'(dt_active), 1);
        step();
        check("zero_lo_rise", int'(gate_lo), 1);
        pwm_in = 1'b1;
        step();
        check("zero_gap2_both", int'({gate_hi, gate_lo}), 0);
        step();
        check("zero_hi_rise", int'(gate_hi), 1);

        // Fault during HI
        fault_in = 1'b1;
        step();
        check("fault_hi_off", int'(gate_hi), 0);
        check("fault_latch", int'(fault_latched), 1);
        check("fault_no_dt", int'(dt_active), 0);
        fault_clr = 1'b1;
        step();
        check("fault_clr_blocked", int'(fault_latched), 1);
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        step();
        check("fault_sticky", int'(fault_latched), 1);
        fault_clr = 1'b1;
        step();
        check("fault_released", int'(fault_latched), 0);
        check("fault_off_state", int'({gate_hi, gate_lo, dt_active}), 0);
        fault_clr = 1'b0;
        dt_cycles = 8'd8;
        wait_hi("after_fault", 8);

        // Reset in the middle of a dead-time interval
        dt_cycles = 8'd16;
        pwm_in    = 1'b0;
        repeat (4) step();
        check("pre_rst_dt", int'(dt_active), 1);
        rst = 1'b1;
        step();
        check("mid_rst_outputs", int'({gate_hi, gate_lo, dt_active, fault_latched}), 0);
        check("mid_rst_counter", int'(dut.u_counter.count_q), 0);

        // Disable while HI
        rst       = 1'b0;
        pwm_in    = 1'b1;
        dt_cycles = 8'd2;
        repeat (3) step();
        check("pre_dis_hi", int'(gate_hi), 1);
        enable = 1'b0;
        step();
        check("dis_outputs", int'({gate_hi, gate_lo, dt_active}), 0);
        step();
        check("dis_held", int'({gate_hi, gate_lo, dt_active}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
